// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: drives one external combinational 4x4
// sub-multiplier over up to four quadrant passes and accumulates a saturated product.
module mul8_seq_ctrl #(
    parameter logic [7:0] QMODE = 8'b01101010,
    parameter bit         ZSKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        sub_en,
    output logic [3:0]  sub_a,
    output logic [3:0]  sub_b,
    output logic [1:0]  sub_sel,
    output logic [1:0]  sub_mode,
    input  logic [7:0]  sub_prod
);

    // Quadrant states carry their sub_sel code in the low two bits.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        DONE = 3'b001,
        LL   = 3'b100,
        LH   = 3'b101,
        HL   = 3'b110,
        HH   = 3'b111
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  a_q, b_q;
    logic [16:0] acc, acc_nx;
    logic [15:0] prod_q;
    logic [1:0]  q;
    logic [1:0]  mode_raw;

    function automatic logic [3:0] nib(input logic [7:0] x, input logic hi);
        return hi ? x[7:4] : x[3:0];
    endfunction

    function automatic logic skip_q(input logic [7:0] x, input logic [7:0] y, input logic [1:0] qq);
        return ZSKIP && ((nib(x, qq[1]) == 4'd0) || (nib(y, qq[0]) == 4'd0));
    endfunction

    // First quadrant at or after index 'from' that is not skipped; DONE if none remain.
    function automatic state_t first_quad(input logic [7:0] x, input logic [7:0] y, input logic [2:0] from);
        state_t r;
        r = DONE;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && !skip_q(x, y, 2'(i)))
                r = state_t'({1'b1, 2'(i)});
        end
        return r;
    endfunction

    assign q        = state[1:0];
    assign mode_raw = QMODE[{q, 1'b0} +: 2];
    assign prod     = prod_q;

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sub_en    = 1'b0;
        sub_a     = 4'd0;
        sub_b     = 4'd0;
        sub_sel   = 2'd0;
        sub_mode  = 2'd0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    acc_nx   = 17'd0;
                    state_nx = first_quad(a, b, 3'd0);
                end
            end
            LL, LH, HL, HH: begin
                sub_en   = 1'b1;
                sub_sel  = q;
                sub_a    = nib(a_q, q[1]);
                sub_b    = nib(b_q, q[0]);
                sub_mode = (mode_raw == 2'b11) ? 2'b00 : mode_raw;
                case (q)
                    2'd0:    acc_nx = acc + {9'd0, sub_prod};
                    2'd3:    acc_nx = acc + {1'b0, sub_prod, 8'd0};
                    default: acc_nx = acc + {5'd0, sub_prod, 4'd0};
                endcase
                state_nx = first_quad(a_q, b_q, {1'b0, q} + 3'd1);
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 17'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            prod_q <= 16'd0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            if (state == IDLE && in_valid) begin
                a_q <= a;
                b_q <= b;
            end
            // prod is captured once on DONE entry so it survives the next accept.
            if (state != DONE && state_nx == DONE)
                prod_q <= acc_nx[16] ? 16'hFFFF : acc_nx[15:0];
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: a no-skip and a zero-skip instance run side by side
// against a quadrant-sum reference model.
module tb_mul8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [7:0] a, b;
    logic [1:0] in_ready, out_valid, sub_en;
    logic [15:0] prod [2];
    logic [3:0]  sub_a [2];
    logic [3:0]  sub_b [2];
    logic [1:0]  sub_sel [2];
    logic [1:0]  sub_mode [2];
    logic [7:0]  sub_prod [2];
    int          smode;   // 0 exact, 1 forced 0xFF, 2 exact xor mode
    int          passed = 0;
    int          total = 0;
    int          mtab [4] = '{2, 2, 2, 1};

    always #5 clk = ~clk;

    function automatic logic [7:0] subm(input logic [3:0] x, input logic [3:0] y, input logic [1:0] md, input int sm);
        logic [7:0] p;
        p = {4'd0, x} * {4'd0, y};
        case (sm)
            0:       return p;
            1:       return 8'hFF;
            default: return p ^ {6'd0, md};
        endcase
    endfunction

    assign sub_prod[0] = subm(sub_a[0], sub_b[0], sub_mode[0], smode);
    assign sub_prod[1] = subm(sub_a[1], sub_b[1], sub_mode[1], smode);

    mul8_seq_ctrl #(.ZSKIP(1'b0)) u_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
        .out_valid(out_valid[0]), .out_ready(out_ready), .prod(prod[0]), .sub_en(sub_en[0]),
        .sub_a(sub_a[0]), .sub_b(sub_b[0]), .sub_sel(sub_sel[0]), .sub_mode(sub_mode[0]),
        .sub_prod(sub_prod[0]));

    mul8_seq_ctrl #(.ZSKIP(1'b1)) u_skip (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
        .out_valid(out_valid[1]), .out_ready(out_ready), .prod(prod[1]), .sub_en(sub_en[1]),
        .sub_a(sub_a[1]), .sub_b(sub_b[1]), .sub_sel(sub_sel[1]), .sub_mode(sub_mode[1]),
        .sub_prod(sub_prod[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int nib_a(input logic [7:0] x, input int qd);
        return (qd >= 2) ? (int'(x) / 16) : (int'(x) % 16);
    endfunction

    function automatic int nib_b(input logic [7:0] x, input int qd);
        return (qd % 2 == 1) ? (int'(x) / 16) : (int'(x) % 16);
    endfunction

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d in_ready", tag, k), 32'(in_ready[k]), 0);
            chk($sformatf("%s u%0d out_valid", tag, k), 32'(out_valid[k]), 0);
            chk($sformatf("%s u%0d prod", tag, k), 32'(prod[k]), 0);
            chk($sformatf("%s u%0d sub", tag, k),
                {18'd0, sub_en[k], sub_a[k], sub_b[k], sub_sel[k], sub_mode[k]}, 0);
        end
    endtask

    // One operation on both instances; out_ready stays low long enough that the
    // earlier finisher sits in DONE under backpressure with junk on the inputs.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb);
        int n [2];
        int vis [2][4];
        int ex [2];
        int an, bn, s, f, qd;
        for (int k = 0; k < 2; k++) begin
            n[k] = 0;
            s = 0;
            for (int j = 0; j < 4; j++) begin
                an = nib_a(xa, j);
                bn = nib_b(xb, j);
                if (k == 1 && (an == 0 || bn == 0)) continue;
                vis[k][n[k]] = j;
                n[k]++;
                f = (smode == 0) ? an * bn : (smode == 1) ? 255 : ((an * bn) ^ mtab[j]);
                s += f * ((j == 0) ? 1 : (j == 3) ? 256 : 16);
            end
            ex[k] = (s > 65535) ? 65535 : s;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("idle u%0d in_ready", k), 32'(in_ready[k]), 1);
            chk($sformatf("idle u%0d sub_en", k), 32'(sub_en[k]), 0);
        end
        a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("op%02h%02h u%0d c%0d in_ready", xa, xb, k, i), 32'(in_ready[k]), 0);
                if (i < n[k]) begin
                    qd = vis[k][i];
                    chk($sformatf("op%02h%02h u%0d c%0d sub_en", xa, xb, k, i), 32'(sub_en[k]), 1);
                    chk($sformatf("op%02h%02h u%0d c%0d sub_sel", xa, xb, k, i), 32'(sub_sel[k]), 32'(qd));
                    chk($sformatf("op%02h%02h u%0d c%0d sub_mode", xa, xb, k, i), 32'(sub_mode[k]), 32'(mtab[qd]));
                    chk($sformatf("op%02h%02h u%0d c%0d sub_ab", xa, xb, k, i),
                        {24'd0, sub_a[k], sub_b[k]}, 32'(nib_a(xa, qd) * 16 + nib_b(xb, qd)));
                    chk($sformatf("op%02h%02h u%0d c%0d out_valid", xa, xb, k, i), 32'(out_valid[k]), 0);
                end else begin
                    chk($sformatf("op%02h%02h u%0d c%0d out_valid", xa, xb, k, i), 32'(out_valid[k]), 1);
                    chk($sformatf("op%02h%02h u%0d c%0d sub_en", xa, xb, k, i), 32'(sub_en[k]), 0);
                    chk($sformatf("op%02h%02h u%0d c%0d prod", xa, xb, k, i), 32'(prod[k]), 32'(ex[k]));
                end
            end
            if (i == 5) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("op%02h%02h u%0d release out_valid", xa, xb, k), 32'(out_valid[k]), 0);
            chk($sformatf("op%02h%02h u%0d release in_ready", xa, xb, k), 32'(in_ready[k]), 1);
            chk($sformatf("op%02h%02h u%0d release prod", xa, xb, k), 32'(prod[k]), 32'(ex[k]));
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; smode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset u0 in_ready", 32'(in_ready[0]), 1);
        chk("post-reset u1 in_ready", 32'(in_ready[1]), 1);

        run_op(8'h12, 8'h34);
        run_op(8'hFF, 8'hFF);
        run_op(8'h05, 8'h07);
        run_op(8'h00, 8'h5A);
        smode = 1;
        run_op(8'hFF, 8'hFF);
        run_op(8'h0F, 8'hF0);

        // Abort in LH with a synchronous reset.
        smode = 0;
        @(negedge clk);
        a = 8'h9B; b = 8'hC7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort u0 in LH", 32'(sub_sel[0]), 1);
        chk("abort u1 in LH", 32'(sub_sel[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("abort idle c%0d u0 out_valid", i), 32'(out_valid[0]), 0);
            chk($sformatf("abort idle c%0d u1 out_valid", i), 32'(out_valid[1]), 0);
            chk($sformatf("abort idle c%0d in_ready", i), 32'(in_ready), 32'h3);
        end
        run_op(8'h12, 8'h34);

        smode = 2;
        for (int r = 0; r < 10; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ra & 8'hF0;
            if ($urandom_range(0, 3) == 0) rb = rb & 8'h0F;
            run_op(ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
